// File: rtl/reg_write_ctrl_pkg.sv
// Shared types and default sizes for the register-file write controller.
package regfile_pkg;

    localparam int N_DEF     = 32;
    localparam int R_DEF     = 7;
    localparam int DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CLEAR
    } state_t;

    typedef struct packed {
        logic [R_DEF-1:0] addr;
        logic [N_DEF-1:0] data;
    } entry_t;

endpackage

// File: rtl/reg_write_ctrl_if.sv
// Writeback-facing request, bypass, control and register-file write port bundle.
interface reg_write_ctrl_if
    import regfile_pkg::*;
#(
    parameter int n     = N_DEF,
    parameter int r     = R_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    logic                     reqValid;
    logic                     reqReady;
    logic [r-1:0]             reqAddr;
    logic [n-1:0]             reqData;
    logic                     clear;
    logic                     busy;
    logic [$clog2(DEPTH):0]   pending;
    logic [r-1:0]             lookupAddr;
    logic                     lookupHit;
    logic [n-1:0]             lookupData;
    logic                     regWrite;
    logic [r-1:0]             writeReg;
    logic [n-1:0]             writeData;

    modport master (
        output reqValid, reqAddr, reqData, clear, lookupAddr,
        input  reqReady, busy, pending, lookupHit, lookupData, regWrite, writeReg, writeData
    );

    modport slave (
        input  reqValid, reqAddr, reqData, clear, lookupAddr,
        output reqReady, busy, pending, lookupHit, lookupData, regWrite, writeReg, writeData
    );
endinterface

// File: rtl/reg_write_ctrl_wr_fifo.sv
// Synchronous FIFO; exposes its contents oldest-first so the owner can search them.
module wr_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  entry_t                 din,
    output entry_t                 head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output entry_t                 entries [DEPTH]
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Index 0 is the oldest entry; higher indices are younger.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries[i] = mem_q[rd_ptr_q + AW'(i)];
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/reg_write_ctrl.sv
// Drains buffered register writes one per cycle, serves bypass lookups, and zeroes the file on clear.
module reg_write_ctrl
    import regfile_pkg::*;
#(
    parameter int n     = N_DEF,
    parameter int r     = R_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input logic             clk,
    input logic             reset,
    reg_write_ctrl_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [r-1:0] addr;
        logic [n-1:0] data;
    } wr_entry_t;

    state_t        state_q, state_d;
    logic [r-1:0]  cnt_q, cnt_d;

    wr_entry_t     din, head;
    wr_entry_t     entries [DEPTH];
    logic          full, empty, push, pop;
    logic [CW-1:0] count;

    logic          ready, reg_write, busy, hit;
    logic [r-1:0]  write_reg;
    logic [n-1:0]  write_data, hit_data;

    assign din  = '{addr: bus.reqAddr, data: bus.reqData};
    assign push = bus.reqValid && ready;

    wr_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (wr_entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .din     (din),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .entries (entries)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ready      = 1'b0;
        pop        = 1'b0;
        reg_write  = 1'b0;
        write_reg  = '0;
        write_data = '0;
        busy       = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready     = !full && !reset;
                pop       = !empty;
                reg_write = !empty;
                if (!empty) begin
                    write_reg  = head.addr;
                    write_data = head.data;
                end
                if (bus.clear) state_d = DRAIN;
            end
            DRAIN: begin
                busy      = 1'b1;
                pop       = !empty;
                reg_write = !empty;
                if (!empty) begin
                    write_reg  = head.addr;
                    write_data = head.data;
                end
                // No pushes here, so one entry left means it leaves at this edge.
                if (count <= CW'(1)) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                busy      = 1'b1;
                reg_write = 1'b1;
                write_reg = cnt_q;
                cnt_d     = cnt_q + r'(1);
                if (cnt_q == '1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Later (younger) matches override earlier ones.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        if (state_q != CLEAR) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((CW'(i) < count) && (entries[i].addr == bus.lookupAddr)) begin
                    hit      = 1'b1;
                    hit_data = entries[i].data;
                end
            end
        end
    end

    assign bus.reqReady   = ready;
    assign bus.busy       = busy;
    assign bus.pending    = count;
    assign bus.lookupHit  = hit;
    assign bus.lookupData = hit_data;
    assign bus.regWrite   = reg_write;
    assign bus.writeReg   = write_reg;
    assign bus.writeData  = write_data;

endmodule

// File: tb/tb_reg_write_ctrl.sv
// Directed bench: vector table for single writes, bypass and ordering, plus clear/reset sequences.
module tb_reg_write_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    reg_write_ctrl_if #(.n(32), .r(7), .DEPTH(4)) bus ();

    reg_write_ctrl #(.n(32), .r(7), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        vld;
        logic [6:0]  addr;
        logic [31:0] data;
        logic [6:0]  look;
        logic        e_rw;
        logic [6:0]  e_reg;
        logic [31:0] e_wd;
        logic [2:0]  e_pend;
        logic        e_hit;
        logic [31:0] e_ld;
        logic        e_rdy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    function automatic vec_t mk(input logic vld, input logic [6:0] addr, input logic [31:0] data,
                                input logic [6:0] look, input logic e_rw, input logic [6:0] e_reg,
                                input logic [31:0] e_wd, input logic [2:0] e_pend,
                                input logic e_hit, input logic [31:0] e_ld);
        vec_t v;
        v = '{vld, addr, data, look, e_rw, e_reg, e_wd, e_pend, e_hit, e_ld, 1'b1};
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_clear;
        logic found;

        reset          = 1'b1;
        bus.reqValid   = 1'b0;
        bus.reqAddr    = '0;
        bus.reqData    = '0;
        bus.clear      = 1'b0;
        bus.lookupAddr = '0;

        // Single write, bypass, and in-order drain of 10..14.
        vecs.push_back(mk(1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 5, 1, 5, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF));
        vecs.push_back(mk(0, 0, 0, 5, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 7, 32'h1, 7, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 7, 32'h2, 8, 1, 7, 32'h1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 7, 1, 7, 32'h2, 1, 1, 32'h2));
        vecs.push_back(mk(0, 0, 0, 7, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) begin
            logic [6:0] a;
            a = 7'(10 + i);
            if (i == 0) vecs.push_back(mk(1, a, 32'h100 + 32'(a), a - 7'd1, 0, 0, 0, 0, 0, 0));
            else vecs.push_back(mk(1, a, 32'h100 + 32'(a), a - 7'd1, 1, a - 7'd1,
                                   32'h100 + 32'(a) - 32'd1, 1, 1, 32'h100 + 32'(a) - 32'd1));
        end
        vecs.push_back(mk(0, 0, 0, 14, 1, 14, 32'h10E, 1, 1, 32'h10E));
        vecs.push_back(mk(0, 0, 0, 14, 0, 0, 0, 0, 0, 0));

        @(negedge clk);
        @(negedge clk);
        #1 chk("rst.ready_in_reset", 32'(bus.reqReady), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst.regWrite", 32'(bus.regWrite), 0);
        chk("rst.writeReg", 32'(bus.writeReg), 0);
        chk("rst.writeData", bus.writeData, 0);
        chk("rst.busy", 32'(bus.busy), 0);
        chk("rst.pending", 32'(bus.pending), 0);
        chk("rst.lookupHit", 32'(bus.lookupHit), 0);
        chk("rst.reqReady", 32'(bus.reqReady), 1);

        foreach (vecs[k]) begin
            @(negedge clk);
            bus.reqValid   = vecs[k].vld;
            bus.reqAddr    = vecs[k].addr;
            bus.reqData    = vecs[k].data;
            bus.lookupAddr = vecs[k].look;
            #1;
            chk($sformatf("v%0d.regWrite", k), 32'(bus.regWrite), 32'(vecs[k].e_rw));
            chk($sformatf("v%0d.writeReg", k), 32'(bus.writeReg), 32'(vecs[k].e_reg));
            chk($sformatf("v%0d.writeData", k), bus.writeData, vecs[k].e_wd);
            chk($sformatf("v%0d.pending", k), 32'(bus.pending), 32'(vecs[k].e_pend));
            chk($sformatf("v%0d.lookupHit", k), 32'(bus.lookupHit), 32'(vecs[k].e_hit));
            chk($sformatf("v%0d.lookupData", k), bus.lookupData, vecs[k].e_ld);
            chk($sformatf("v%0d.reqReady", k), 32'(bus.reqReady), 32'(vecs[k].e_rdy));
        end

        // Clear with a queued write; requests held and clear re-pulsed must have no effect.
        @(negedge clk);
        bus.reqValid = 1'b1; bus.reqAddr = 7'd20; bus.reqData = 32'hAA;
        #1 chk("clr.pre_rw", 32'(bus.regWrite), 0);
        @(negedge clk);
        bus.reqAddr = 7'd21; bus.reqData = 32'hBB; bus.clear = 1'b1;
        #1;
        chk("clr.issue20_reg", 32'(bus.writeReg), 20);
        chk("clr.issue20_data", bus.writeData, 32'hAA);
        chk("clr.busy_before", 32'(bus.busy), 0);
        @(negedge clk);
        bus.reqAddr = 7'd22; bus.reqData = 32'hCC;
        #1;
        chk("drain.busy", 32'(bus.busy), 1);
        chk("drain.ready", 32'(bus.reqReady), 0);
        chk("drain.reg", 32'(bus.writeReg), 21);
        chk("drain.data", bus.writeData, 32'hBB);
        chk("drain.pending", 32'(bus.pending), 1);
        @(negedge clk);
        bus.clear = 1'b0;
        #1;
        n_clear = 0;
        for (int c = 0; c < 300; c++) begin
            if (!bus.busy) break;
            chk($sformatf("clr%0d.write", n_clear),
                {bus.regWrite, bus.reqReady, bus.pending, 20'd0, bus.writeReg},
                {1'b1, 1'b0, 3'd0, 20'd0, 7'(n_clear)});
            chk($sformatf("clr%0d.data", n_clear), bus.writeData, 0);
            bus.clear = (n_clear == 10);
            n_clear++;
            @(negedge clk);
            #1;
        end
        bus.clear = 1'b0;
        chk("clr.length", 32'(n_clear), 128);
        chk("clr.end_busy", 32'(bus.busy), 0);
        chk("clr.end_ready", 32'(bus.reqReady), 1);
        chk("clr.end_rw", 32'(bus.regWrite), 0);
        @(negedge clk);
        bus.reqValid = 1'b0;
        #1;
        chk("post.reg", 32'(bus.writeReg), 22);
        chk("post.data", bus.writeData, 32'hCC);

        // Reset while the clear sweep is at address 40.
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 300; c++) begin
            #1;
            if (bus.busy && bus.regWrite && bus.writeReg == 7'd40) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("rstclr.reach40", 32'(found), 1);
        reset = 1'b1;
        #1 chk("rstclr.ready_in_reset", 32'(bus.reqReady), 0);
        @(negedge clk);
        #1;
        chk("rstclr.rw", 32'(bus.regWrite), 0);
        chk("rstclr.busy", 32'(bus.busy), 0);
        chk("rstclr.pending", 32'(bus.pending), 0);
        reset = 1'b0;
        #1 chk("rstclr.ready_after", 32'(bus.reqReady), 1);
        @(negedge clk);
        #1;
        chk("rstclr.idle_rw", 32'(bus.regWrite), 0);
        chk("rstclr.idle_busy", 32'(bus.busy), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
